// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: latches packed nibbles, scans one
// digit per refresh period with a leading blank window, decodes hex/dec with dp and LZ suppression.
module seven_seg_scan_driver #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter bit          HEX_EN       = 1'b1,
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  lz_suppress,
    output logic [7:0]            Seven_Segment,
    output logic [DIGITS-1:0]     an,
    output logic [IDX_W-1:0]      digit_idx
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned VAL_W = 4 * DIGITS;

    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [VAL_W-1:0]  val_r, val_nxt;
    logic [DIGITS-1:0] dp_r, dp_nxt;

    logic [7:0]        seg_nxt;
    logic [DIGITS-1:0] an_nxt;

    logic [3:0]        nibs [DIGITS];
    logic [DIGITS-1:0] lead_zero;

    // Nibble n maps to active-low g..a; nibbles above 9 blank when hex decode is disabled.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        if (!HEX_EN && (n > 4'd9)) begin
            s = 7'h7F;
        end
        return s;
    endfunction

    // lead_zero[g]: every nibble from the top digit down to g is zero.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign nibs[g]      = val_r[4*g +: 4];
        assign lead_zero[g] = ~|val_r[VAL_W-1:4*g];
    end

    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        idx_nxt = idx;
        val_nxt = val_r;
        dp_nxt  = dp_r;
        if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_nxt = '0;
            if (DIGITS > 1) begin
                idx_nxt = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end
        end
        if (load) begin
            val_nxt = value;
            dp_nxt  = dp_in;
        end
    end

    // Output image is built from the current scan state and lands one edge later.
    always_comb begin
        seg_nxt = 8'hFF;
        an_nxt  = '1;
        if (cnt >= CNT_W'(BLANK_CYCLES)) begin
            an_nxt       = ~(DIGITS'(1) << idx);
            seg_nxt[7]   = ~dp_r[idx];
            seg_nxt[6:0] = decode(nibs[idx]);
            if (lz_suppress && (idx != '0) && lead_zero[idx]) begin
                seg_nxt[6:0] = 7'h7F;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            idx           <= '0;
            val_r         <= '0;
            dp_r          <= '0;
            Seven_Segment <= 8'hFF;
            an            <= '1;
            digit_idx     <= '0;
        end else begin
            cnt           <= cnt_nxt;
            idx           <= idx_nxt;
            val_r         <= val_nxt;
            dp_r          <= dp_nxt;
            Seven_Segment <= seg_nxt;
            an            <= an_nxt;
            digit_idx     <= idx;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: hex and decimal-only instances run in lockstep against
// a time-indexed reference model; each scenario task checks its own outputs.
module tb_seven_seg_scan_driver;

    localparam int unsigned D = 4;
    localparam int unsigned R = 8;
    localparam int unsigned B = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        lz = 1'b0;

    logic [7:0]  seg, seg_nh;
    logic [3:0]  an, an_nh;
    logic [1:0]  didx, didx_nh;

    int compared = 0;
    int mismatched = 0;

    seven_seg_scan_driver #(.DIGITS(D), .REFRESH_DIV(R), .BLANK_CYCLES(B), .HEX_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load), .lz_suppress(lz),
        .Seven_Segment(seg), .an(an), .digit_idx(didx)
    );

    seven_seg_scan_driver #(.DIGITS(D), .REFRESH_DIV(R), .BLANK_CYCLES(B), .HEX_EN(1'b0)) u_dut_nohex (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load), .lz_suppress(lz),
        .Seven_Segment(seg_nh), .an(an_nh), .digit_idx(didx_nh)
    );

    always #5 clk = ~clk;

    // Reference: the k-th cycle since reset belongs to digit (k/R)%D at offset k%R.
    logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int unsigned m_s;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [7:0]  exp_seg, exp_seg_nh;
    logic [3:0]  exp_an;
    logic [1:0]  exp_idx;

    always @(posedge clk) begin
        int unsigned d, off;
        logic [3:0]  nib;
        logic        blank;
        if (rst) begin
            m_s = 0; m_val = '0; m_dp = '0;
            exp_seg = 8'hFF; exp_seg_nh = 8'hFF; exp_an = 4'hF; exp_idx = '0;
        end else begin
            d   = (m_s / R) % D;
            off = m_s % R;
            exp_idx = 2'(d);
            if (off < B) begin
                exp_seg = 8'hFF; exp_seg_nh = 8'hFF; exp_an = 4'hF;
            end else begin
                nib   = 4'(m_val >> (4 * d));
                blank = lz && (d != 0) && ((m_val >> (4 * d)) == 16'd0);
                exp_seg    = blank ? 8'hFF : seg_tab[nib];
                exp_seg_nh = (blank || nib > 4'd9) ? 8'hFF : seg_tab[nib];
                if (m_dp[d]) begin
                    exp_seg[7] = 1'b0; exp_seg_nh[7] = 1'b0;
                end
                exp_an = ~(4'b0001 << d);
            end
            m_s++;
            if (load) begin
                m_val = value; m_dp = dp_in;
            end
        end
    end

    // Reset, then load on the release edge so digit 0's first active cycle already shows v.
    task automatic restart(input logic [15:0] v, input logic [3:0] d);
        @(negedge clk); rst = 1'b1; load = 1'b0;
        @(negedge clk); rst = 1'b0; load = 1'b1; value = v; dp_in = d;
        @(negedge clk); load = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if ({seg, an, didx} !== {8'hFF, 4'hF, 2'd0}) begin
                mismatched++;
                $display("FAIL reset_hold: got %h/%b/%0d want FF/1111/0", seg, an, didx);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if ({seg, an, didx} !== {8'hFF, 4'hF, 2'd0}) begin
            mismatched++;
            $display("FAIL reset_release: got %h/%b/%0d want FF/1111/0", seg, an, didx);
        end
        n = 1;
        while (an !== 4'b1110 && n < 20) begin
            @(negedge clk); n++;
        end
        compared++;
        if (n != 3) begin
            mismatched++;
            $display("FAIL reset_first_an: got %0d cycles want 3", n);
        end
    endtask

    task automatic test_scan_order();
        logic [7:0] want [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        lz = 1'b0;
        restart(16'h1234, 4'b0000);
        for (int k = 0; k < int'(2 * R * D); k++) begin
            compared++;
            if ({seg, an, didx, seg_nh, an_nh, didx_nh} !== {exp_seg, exp_an, exp_idx, exp_seg_nh, exp_an, exp_idx}) begin
                mismatched++;
                $display("FAIL scan_model k=%0d: got %h/%b/%0d nh %h/%b/%0d want %h/%b/%0d nh %h",
                         k, seg, an, didx, seg_nh, an_nh, didx_nh, exp_seg, exp_an, exp_idx, exp_seg_nh);
            end
            if (k % R == 4) begin
                compared++;
                if ({an, seg} !== {~(4'b0001 << ((k / R) % D)), want[(k / R) % D]}) begin
                    mismatched++;
                    $display("FAIL scan_digit k=%0d: got %b/%h want %b/%h", k, an, seg,
                             ~(4'b0001 << ((k / R) % D)), want[(k / R) % D]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hex_dp();
        logic [7:0] want_hex [4] = '{8'h0E, 8'hC6, 8'h83, 8'h88};
        logic [7:0] want_dec [4] = '{8'h7F, 8'hFF, 8'hFF, 8'hFF};
        lz = 1'b0;
        restart(16'hABCF, 4'b0001);
        for (int k = 0; k < int'(R * D); k++) begin
            compared++;
            if ({seg, an, seg_nh} !== {exp_seg, exp_an, exp_seg_nh}) begin
                mismatched++;
                $display("FAIL hex_model k=%0d: got %h/%b nh %h want %h/%b nh %h",
                         k, seg, an, seg_nh, exp_seg, exp_an, exp_seg_nh);
            end
            if (k % R == 5) begin
                compared++;
                if ({seg, seg_nh} !== {want_hex[k / R], want_dec[k / R]}) begin
                    mismatched++;
                    $display("FAIL hex_digit %0d: got %h nh %h want %h nh %h",
                             k / R, seg, seg_nh, want_hex[k / R], want_dec[k / R]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lz_suppress();
        logic [15:0] vals [2] = '{16'h0050, 16'h0000};
        logic [7:0]  want [2][4] = '{'{8'hC0, 8'h92, 8'hFF, 8'hFF}, '{8'hC0, 8'hFF, 8'hFF, 8'hFF}};
        lz = 1'b1;
        for (int t = 0; t < 2; t++) begin
            restart(vals[t], 4'b0000);
            for (int k = 0; k < int'(R * D); k++) begin
                if (k % R == 3) begin
                    compared++;
                    if ({seg, an} !== {want[t][k / R], ~(4'b0001 << (k / R))} || seg !== exp_seg) begin
                        mismatched++;
                        $display("FAIL lz_digit v=%h d=%0d: got %h/%b want %h (model %h)",
                                 vals[t], k / R, seg, an, want[t][k / R], exp_seg);
                    end
                end
                @(negedge clk);
            end
        end
        lz = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        int n;
        lz = 1'b0;
        restart(16'h1234, 4'b0000);
        repeat (21) @(negedge clk);
        compared++;
        if ({an, seg} !== {4'b1011, 8'hA4}) begin
            mismatched++;
            $display("FAIL mid_pre: got %b/%h want 1011/A4", an, seg);
        end
        rst = 1'b1; load = 1'b1; value = 16'h9999;
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        compared++;
        if ({seg, an, didx} !== {8'hFF, 4'hF, 2'd0}) begin
            mismatched++;
            $display("FAIL mid_rst: got %h/%b/%0d want FF/1111/0", seg, an, didx);
        end
        n = 0;
        while (an !== 4'b1110 && n < 20) begin
            @(negedge clk); n++;
        end
        compared++;
        if (n != 3 || seg !== 8'hC0 || didx !== 2'd0) begin
            mismatched++;
            $display("FAIL mid_restart: got %0d cycles seg %h idx %0d want 3 C0 0", n, seg, didx);
        end
    endtask

    task automatic test_load_during_scan();
        lz = 1'b0;
        restart(16'h1234, 4'b0000);
        repeat (3) @(negedge clk);
        load = 1'b1; value = 16'h0007; dp_in = 4'b0000;
        @(negedge clk);
        load = 1'b0;
        compared++;
        if ({an, seg} !== {4'b1110, 8'h99}) begin
            mismatched++;
            $display("FAIL load_edge1: got %b/%h want 1110/99", an, seg);
        end
        @(negedge clk);
        compared++;
        if ({an, seg, didx} !== {4'b1110, 8'hF8, 2'd0}) begin
            mismatched++;
            $display("FAIL load_edge2: got %b/%h/%0d want 1110/F8/0", an, seg, didx);
        end
        for (int k = 5; k < int'(2 * R * D); k++) begin
            @(negedge clk);
            compared++;
            if ({seg, an, didx} !== {exp_seg, exp_an, exp_idx}) begin
                mismatched++;
                $display("FAIL load_model k=%0d: got %h/%b/%0d want %h/%b/%0d",
                         k, seg, an, didx, exp_seg, exp_an, exp_idx);
            end
        end
    endtask

    task automatic test_random();
        restart(16'($urandom), 4'($urandom));
        for (int k = 0; k < 600; k++) begin
            compared++;
            if ({seg, an, didx, seg_nh, an_nh, didx_nh} !== {exp_seg, exp_an, exp_idx, exp_seg_nh, exp_an, exp_idx}) begin
                mismatched++;
                $display("FAIL random k=%0d: got %h/%b/%0d nh %h want %h/%b/%0d nh %h",
                         k, seg, an, didx, seg_nh, exp_seg, exp_an, exp_idx, exp_seg_nh);
            end
            value = 16'($urandom);
            dp_in = 4'($urandom);
            load  = ($urandom_range(0, 5) == 0);
            lz    = 1'($urandom);
            rst   = ($urandom_range(0, 79) == 0);
            @(negedge clk);
        end
        rst = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_hex_dp();
        test_lz_suppress();
        test_reset_mid_scan();
        test_load_during_scan();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
